// File: rtl/v810_bus_arb_if.sv
// Bus bundle between the EU instruction/data channels, the arbiter and the MAU request port.
// Handshake: a requester holds xREQ until its one-cycle xACK; MREQ is held until MACK.
interface v810_bus_arb_if;
    logic [31:0] IA;
    logic        IREQ;
    logic [31:0] ID;
    logic        IACK;
    logic [31:0] DA;
    logic [31:0] DD_O;
    logic [31:0] DD_I;
    logic [1:0]  DBC;
    logic [3:0]  DBE;
    logic        DWR;
    logic        DREQ;
    logic        DACK;
    logic [31:0] MA;
    logic [31:0] MD_O;
    logic [31:0] MD_I;
    logic [1:0]  MBC;
    logic [3:0]  MBE;
    logic        MWR;
    logic        MREQ;
    logic        MACK;
    logic        GNT_D;
    logic [1:0]  DBG_STATE;

    modport slave (
        input  IA, IREQ, DA, DD_O, DBC, DBE, DWR, DREQ, MD_I, MACK,
        output ID, IACK, DD_I, DACK, MA, MD_O, MBC, MBE, MWR, MREQ, GNT_D, DBG_STATE
    );

    modport master (
        output IA, IREQ, DA, DD_O, DBC, DBE, DWR, DREQ, MD_I, MACK,
        input  ID, IACK, DD_I, DACK, MA, MD_O, MBC, MBE, MWR, MREQ, GNT_D, DBG_STATE
    );
endinterface

// File: rtl/v810_bus_arb.sv
// Shares the single MAU request port between EU instruction fetch and EU data channels.
// Data has priority; a starvation counter forces an instruction grant after STARVE_LIMIT data grants.
module v810_bus_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            CLK,
    input  logic            RESn,
    input  logic            CE,
    v810_bus_arb_if.slave   bus
);
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [31:0]   r_ma, w_ma_nx;
    logic [31:0]   r_md, w_md_nx;
    logic [1:0]    r_bc, w_bc_nx;
    logic [3:0]    r_be, w_be_nx;
    logic          r_wr, w_wr_nx;
    logic          r_gnt_d, w_gnt_d_nx;
    logic          w_starve;

    // Forcing an instruction grant only applies when a fetch is actually waiting.
    assign w_starve = bus.IREQ && (STARVE_LIMIT != 0) && (r_cnt == LIMIT_C);

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ma    <= '0;
            r_md    <= '0;
            r_bc    <= '0;
            r_be    <= '0;
            r_wr    <= 1'b0;
            r_gnt_d <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ma    <= w_ma_nx;
            r_md    <= w_md_nx;
            r_bc    <= w_bc_nx;
            r_be    <= w_be_nx;
            r_wr    <= w_wr_nx;
            r_gnt_d <= w_gnt_d_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ma_nx    = r_ma;
        w_md_nx    = r_md;
        w_bc_nx    = r_bc;
        w_be_nx    = r_be;
        w_wr_nx    = r_wr;
        w_gnt_d_nx = r_gnt_d;
        if (CE) begin
            case (r_state)
                IDLE: begin
                    if (bus.DREQ && !w_starve) begin
                        w_state_nx = DGNT;
                        w_ma_nx    = bus.DA;
                        w_md_nx    = bus.DD_O;
                        w_bc_nx    = bus.DBC;
                        w_be_nx    = bus.DBE;
                        w_wr_nx    = bus.DWR;
                        w_gnt_d_nx = 1'b1;
                        if (!bus.IREQ)
                            w_cnt_nx = '0;
                        else if (r_cnt != LIMIT_C)
                            w_cnt_nx = r_cnt + 1'b1;
                    end else if (bus.IREQ) begin
                        w_state_nx = IGNT;
                        w_ma_nx    = bus.IA;
                        w_md_nx    = '0;
                        w_bc_nx    = 2'b10;
                        w_be_nx    = 4'hF;
                        w_wr_nx    = 1'b0;
                        w_gnt_d_nx = 1'b0;
                        w_cnt_nx   = '0;
                    end
                end
                IGNT, DGNT: begin
                    if (bus.MACK)
                        w_state_nx = IDLE;
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    assign bus.MREQ      = (r_state != IDLE);
    assign bus.MA        = r_ma;
    assign bus.MD_O      = r_md;
    assign bus.MBC       = r_bc;
    assign bus.MBE       = r_be;
    assign bus.MWR       = r_wr;
    assign bus.GNT_D     = r_gnt_d;
    assign bus.IACK      = bus.MACK && CE && (r_state == IGNT);
    assign bus.DACK      = bus.MACK && CE && (r_state == DGNT);
    assign bus.ID        = bus.MD_I;
    assign bus.DD_I      = bus.MD_I;
    assign bus.DBG_STATE = r_state;
endmodule

// File: doc/v810_bus_arb.md
Name: v810_bus_arb

Overview:
- Two-requester arbiter that shares one MAU request port between the EU instruction-fetch channel (IA/ID/IREQ/IACK) and the EU data channel (DA/DD/DBC/DBE/DWR/DREQ/DACK).
- Sits between v810_exec and the MAU's single request port. One transaction is outstanding at a time.
- Data requests have priority. A starvation counter guarantees that instruction fetches make forward progress.

Parameters:
STARVE_LIMIT, 4, number of consecutive data grants made while IREQ is pending before the next grant is forced to the instruction channel; 0 = strict data priority, never forced
CW, $clog2(STARVE_LIMIT+1) (minimum 1), starvation counter width; derived, do not override

Ports:
CLK  in  1  clock
RESn  in  1  reset; asynchronous, active-low
CE  in  1  clock enable; state updates only on CLK edges with CE=1
IA  in  32  instruction fetch address, word aligned
IREQ  in  1  instruction request, held until IACK
ID  out  32  fetched instruction word
IACK  out  1  one-cycle acknowledge of the instruction transaction
DA  in  32  data address
DD_O  in  32  write data from EU
DD_I  out  32  read data to EU
DBC  in  2  data size code: 00 byte, 01 halfword, 10 word
DBE  in  4  data byte enables
DWR  in  1  1 = write
DREQ  in  1  data request, held until DACK
DACK  out  1  one-cycle acknowledge of the data transaction
MA  out  32  MAU address
MD_O  out  32  MAU write data
MD_I  in  32  MAU read data
MBC  out  2  MAU size code
MBE  out  4  MAU byte enables
MWR  out  1  MAU write
MREQ  out  1  MAU request, held until MACK
MACK  in  1  MAU one-cycle acknowledge
GNT_D  out  1  debug: current grant is data (valid while MREQ=1)

Behaviour:
- Reset (RESn=0, async):
  - State goes to IDLE; starvation counter cleared.
  - MREQ=0, MWR=0, GNT_D=0, MA=0, MD_O=0, MBC=0, MBE=0.
  - IACK=0, DACK=0.
- States: IDLE, IGNT, DGNT.
- IDLE, on a CE edge:
  - If DREQ=1 and not (IREQ=1 and cnt==STARVE_LIMIT and STARVE_LIMIT!=0): go to DGNT and latch MA=DA, MD_O=DD_O, MBC=DBC, MBE=DBE, MWR=DWR, GNT_D=1.
  - Else if IREQ=1: go to IGNT and latch MA=IA, MD_O=0, MBC=2'b10, MBE=4'hF, MWR=0, GNT_D=0.
  - MREQ is registered and rises on the same edge, so request-to-MREQ latency is 1 cycle.
- Counter:
  - Increments (saturating at STARVE_LIMIT) on each DGNT entry made while IREQ=1.
  - Clears on IGNT entry, and on a DGNT entry made while IREQ=0.
- IGNT/DGNT:
  - MA, MD_O, MBC, MBE, MWR and MREQ are held stable.
  - IACK = MACK & CE & (state==IGNT); DACK = MACK & CE & (state==DGNT). Both are combinational.
  - ID and DD_I are driven continuously from MD_I; they are valid only while the corresponding ACK is 1.
  - On a CE edge with MACK=1: return to IDLE and drop MREQ.
- Back-to-back: a REQ still high in the cycle after its ACK is a new request. It is sampled in IDLE, so there is a minimum of 1 idle cycle between MAU transactions.
- Requester drops REQ before ACK (protocol violation): the MAU transaction still runs to MACK; the ACK still pulses.
- CE=0: state, counter and all registered outputs are frozen; IACK and DACK are 0.
- Simultaneous IREQ and DREQ in IDLE: data wins unless the starvation condition holds.
- Reset mid-transaction: MREQ drops immediately. A MACK arriving after reset is ignored.

Test Plan:
- Single fetch: IREQ=1, IA=0x8000_0010, MAU acks after 2 cycles with MD_I=0x1234_5678 -> MREQ 1 cycle after IREQ, MBC=10, MBE=F, MWR=0; IACK pulses once with ID=0x1234_5678.
- Data write: DREQ=1, DA=0x40, DD_O=0xDEADBEEF, DBC=01, DBE=0011, DWR=1 -> MAU port carries these values unchanged; DACK coincides with MACK; GNT_D=1.
- Tie: IREQ and DREQ rise in the same cycle -> data granted first; instruction granted after 1 idle cycle.
- Starvation, STARVE_LIMIT=4: IREQ held while DREQ is re-asserted continuously -> exactly 4 data grants, then 1 instruction grant, then data again.
- Reset mid-op: RESn=0 while in DGNT before MACK -> MREQ=0 asynchronously; a MACK after reset produces no DACK.
- CE gating: CE=0 for 3 cycles during IGNT with MACK=1 -> no IACK and MREQ held; CE=1 -> IACK on the first enabled cycle.
